// File: rtl/reg_bank_file.sv
// Banked register file (NUM_BANKS x REGS_PER_BANK words), 1 write port, 2 read ports, hardware bank-clear sequencer.
// Latency: reads are combinational (0 cycles); writes are visible the cycle after the write edge; a clear takes REGS_PER_BANK+1 busy cycles.
// Backpressure: none is exerted; writes offered while clr_busy=1 are discarded and flagged on wr_drop, and clr_req while busy is ignored.
//
// Optional build macro: REG_BANK_BYPASS_EN
//   defined   -> a write to the same valid word as a read port is forwarded to that read port in the same cycle
//   undefined -> read ports show the stored value until the cycle after the write
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset (zeroes every word, aborts any clear)
//   bank_sel            active bank for the read and write ports (PSW.RS1:RS0)
//   we, waddr, wdata    write port, index within the active bank
//   raddr_a, rdata_a    read port A, index within the active bank
//   raddr_b, rdata_b    read port B, index within the active bank
//   clr_req             request a clear of the active bank (only accepted while idle)
//   clr_busy            clear sequence in progress (CLEAR and DONE states)
//   clr_done            one-cycle pulse once the last word of the bank has been cleared
//   wr_drop             one-cycle pulse the cycle after a write was discarded during a clear

module reg_bank_file #(
    parameter int DATA_W        = 8,
    parameter int NUM_BANKS     = 4,
    parameter int REGS_PER_BANK = 8,
    localparam int BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int REG_W        = $clog2(REGS_PER_BANK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int DEPTH  = NUM_BANKS * REGS_PER_BANK;
    localparam int PHYS_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [REG_W-1:0] LAST_IDX = REG_W'(REGS_PER_BANK - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Flat storage; bank b, word r lives at b*REGS_PER_BANK + r.
    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [BANK_W-1:0] clr_bank;
    logic [REG_W-1:0]  idx;

    logic              bank_ok;
    logic              waddr_ok;
    logic              raddr_a_ok;
    logic              raddr_b_ok;
    logic              wr_ok;
    logic [PHYS_W-1:0] wphys;
    logic [PHYS_W-1:0] rphys_a;
    logic [PHYS_W-1:0] rphys_b;
    logic [PHYS_W-1:0] cphys;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;

    function automatic logic [PHYS_W-1:0] phys_idx(input logic [BANK_W-1:0] b,
                                                   input logic [REG_W-1:0]  a);
        return PHYS_W'(32'(b) * REGS_PER_BANK + 32'(a));
    endfunction

    // When NUM_BANKS / REGS_PER_BANK are not powers of two the select and
    // address fields can name words that do not exist; those behave as an
    // unbacked location (read 0, write ignored).
    assign bank_ok    = (32'(bank_sel) < NUM_BANKS);
    assign waddr_ok   = (32'(waddr)    < REGS_PER_BANK);
    assign raddr_a_ok = (32'(raddr_a)  < REGS_PER_BANK);
    assign raddr_b_ok = (32'(raddr_b)  < REGS_PER_BANK);

    assign wphys   = phys_idx(bank_sel, waddr);
    assign rphys_a = phys_idx(bank_sel, raddr_a);
    assign rphys_b = phys_idx(bank_sel, raddr_b);
    assign cphys   = phys_idx(clr_bank, idx);

    // The clear owns the array for its whole busy window, including DONE, so
    // the write port and the clear never collide on the same edge.
    assign wr_ok = we & ~clr_busy & bank_ok & waddr_ok;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (state == S_CLEAR) begin
            mem[cphys] <= '0;
        end else if (wr_ok) begin
            mem[wphys] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            clr_bank <= '0;
            idx      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            // Any write attempt during the busy window is dropped, whichever bank it targets.
            wr_drop  <= we & clr_busy;

            case (state)
                S_IDLE: begin
                    if (clr_req) begin
                        clr_bank <= bank_sel;
                        idx      <= '0;
                        clr_busy <= 1'b1;
                        if (bank_ok) begin
                            state <= S_CLEAR;
                        end else begin
                            // Nothing to clear: report completion straight away.
                            state    <= S_DONE;
                            clr_done <= 1'b1;
                        end
                    end
                end

                S_CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state    <= S_DONE;
                        clr_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                S_DONE: begin
                    state    <= S_IDLE;
                    clr_busy <= 1'b0;
                end

                default: begin
                    state    <= S_IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        stored_a = '0;
        if (bank_ok && raddr_a_ok) begin
            stored_a = mem[rphys_a];
        end
    end

    always_comb begin
        stored_b = '0;
        if (bank_ok && raddr_b_ok) begin
            stored_b = mem[rphys_b];
        end
    end

`ifdef REG_BANK_BYPASS_EN
    // Forward only a write that will actually commit this edge, so a dropped
    // write never appears on a read port.
    always_comb begin
        rdata_a = stored_a;
        if (wr_ok && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = stored_b;
        if (wr_ok && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end
`else
    assign rdata_a = stored_a;
    assign rdata_b = stored_b;
`endif

endmodule

// File: tb/tb_reg_bank_file.sv
// Self-checking bench for reg_bank_file (default 4 banks x 8 words x 8 bits).
// Stimulus drives one input vector per cycle and pushes the predicted outputs into a queue; a monitor pops and compares on the falling edge.
// The reference model keeps a 2-D word array plus a busy-cycle countdown for the clear.

module tb_reg_bank_file;

    localparam int DATA_W = 8;
    localparam int NB     = 4;
    localparam int R      = 8;
    localparam int BANK_W = 2;
    localparam int REG_W  = 3;

    logic              clk;
    logic              rst;
    logic [BANK_W-1:0] bank_sel;
    logic              we;
    logic [REG_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  raddr_a;
    logic [DATA_W-1:0] rdata_a;
    logic [REG_W-1:0]  raddr_b;
    logic [DATA_W-1:0] rdata_b;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;
    logic              wr_drop;

    reg_bank_file #(
        .DATA_W(DATA_W),
        .NUM_BANKS(NB),
        .REGS_PER_BANK(R)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bank_sel(bank_sel),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr_a(raddr_a),
        .rdata_a(rdata_a),
        .raddr_b(raddr_b),
        .rdata_b(rdata_b),
        .clr_req(clr_req),
        .clr_busy(clr_busy),
        .clr_done(clr_done),
        .wr_drop(wr_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       we;
        logic       clr;
        int         bank;
        int         waddr;
        logic [7:0] wdata;
        int         ra;
        int         rb;
    } stim_t;

    typedef struct {
        logic [7:0] ra;
        logic [7:0] rb;
        logic       busy;
        logic       done;
        logic       drop;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] ref_mem [NB][R];
    int         busy_left = 0;   // busy cycles remaining, counting the current one
    int         cleared   = 0;   // words of clr_bank already zeroed
    int         cbank     = 0;
    logic       drop_q    = 1'b0;

    stim_t cur;

    function automatic stim_t mk(input logic r, input logic w, input logic c, input int b,
                                 input int wa, input logic [7:0] wd, input int a, input int bb);
        stim_t s;
        s.rst = r; s.we = w; s.clr = c; s.bank = b;
        s.waddr = wa; s.wdata = wd; s.ra = a; s.rb = bb;
        return s;
    endfunction

    // Advance the model by one clock edge using the inputs held during the cycle.
    task automatic model_step(input stim_t s);
        if (s.rst) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < R; r++)
                    ref_mem[b][r] = 8'h00;
            busy_left = 0;
            cleared   = 0;
            drop_q    = 1'b0;
        end else begin
            drop_q = s.we && (busy_left > 0);
            if (busy_left > 0) begin
                if (cleared < R) begin
                    ref_mem[cbank][cleared] = 8'h00;
                    cleared++;
                end
                busy_left--;
            end else begin
                if (s.we && s.bank < NB)
                    ref_mem[s.bank][s.waddr] = s.wdata;
                if (s.clr) begin
                    cbank = s.bank;
                    if (s.bank < NB) begin
                        busy_left = R + 1;
                        cleared   = 0;
                    end else begin
                        busy_left = 1;
                        cleared   = R;
                    end
                end
            end
        end
    endtask

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        logic valid;
        valid  = (s.bank < NB);
        e.busy = (busy_left > 0);
        e.done = (busy_left == 1);
        e.drop = drop_q;
        e.ra   = valid ? ref_mem[s.bank][s.ra] : 8'h00;
        e.rb   = valid ? ref_mem[s.bank][s.rb] : 8'h00;
`ifdef REG_BANK_BYPASS_EN
        if (s.we && !e.busy && valid && s.waddr == s.ra) e.ra = s.wdata;
        if (s.we && !e.busy && valid && s.waddr == s.rb) e.rb = s.wdata;
`endif
        return e;
    endfunction

    task automatic drive(input stim_t s);
        rst      = s.rst;
        we       = s.we;
        clr_req  = s.clr;
        bank_sel = BANK_W'(s.bank);
        waddr    = REG_W'(s.waddr);
        wdata    = s.wdata;
        raddr_a  = REG_W'(s.ra);
        raddr_b  = REG_W'(s.rb);
        cur      = s;
    endtask

    // One cycle: the edge consumes the held inputs, then new inputs are applied
    // and their expected outputs queued for the monitor.
    task automatic apply(input stim_t s);
        @(posedge clk);
        model_step(cur);
        #1;
        drive(s);
        exp_q.push_back(predict(s));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rdata_a",  32'(rdata_a),  32'(e.ra));
                check("rdata_b",  32'(rdata_b),  32'(e.rb));
                check("clr_busy", 32'(clr_busy), 32'(e.busy));
                check("clr_done", 32'(clr_done), 32'(e.done));
                check("wr_drop",  32'(wr_drop),  32'(e.drop));
            end
        end
    end

    task automatic idle(input int n, input int b);
        for (int i = 0; i < n; i++)
            apply(mk(1'b0, 1'b0, 1'b0, b, 0, 8'h00, i % R, (R - 1) - (i % R)));
    endtask

    task automatic read_bank(input int b);
        for (int r = 0; r < R; r += 2)
            apply(mk(1'b0, 1'b0, 1'b0, b, 0, 8'h00, r, r + 1));
    endtask

    initial begin
        drive(mk(1'b1, 1'b0, 1'b0, 0, 0, 8'h00, 0, 0));

        // Reset: one cycle of rst, then every word of every bank reads zero.
        apply(mk(1'b0, 1'b0, 1'b0, 0, 0, 8'h00, 0, 1));
        for (int b = 0; b < NB; b++) read_bank(b);

        // Bank isolation.
        apply(mk(1'b0, 1'b1, 1'b0, 1, 3, 8'hA5, 0, 0));
        apply(mk(1'b0, 1'b0, 1'b0, 2, 0, 8'h00, 3, 3));
        apply(mk(1'b0, 1'b0, 1'b0, 1, 0, 8'h00, 3, 2));

        // Write/read on the same word in one cycle, then the following cycle.
        apply(mk(1'b0, 1'b1, 1'b0, 0, 5, 8'h11, 0, 0));
        apply(mk(1'b0, 1'b1, 1'b0, 0, 5, 8'h3C, 5, 4));
        apply(mk(1'b0, 1'b0, 1'b0, 0, 0, 8'h00, 5, 5));

        // Clear: fill bank 0 with 1..8 and bank 1 with a pattern, clear bank 0.
        for (int r = 0; r < R; r++) apply(mk(1'b0, 1'b1, 1'b0, 0, r, 8'(r + 1), r, 0));
        for (int r = 0; r < R; r++) apply(mk(1'b0, 1'b1, 1'b0, 1, r, 8'(8'h80 + r), r, 0));
        apply(mk(1'b0, 1'b0, 1'b1, 0, 0, 8'h00, 0, 7));
        idle(R + 2, 0);
        read_bank(0);
        read_bank(1);

        // Drop: write to bank 3 during a clear of bank 0.
        apply(mk(1'b0, 1'b1, 1'b0, 3, 0, 8'h5A, 0, 0));
        apply(mk(1'b0, 1'b0, 1'b1, 0, 0, 8'h00, 0, 0));
        apply(mk(1'b0, 1'b1, 1'b0, 3, 0, 8'hFF, 0, 1));
        idle(R + 1, 3);
        read_bank(3);

        // Abort: rst during clear cycle 4, then a new request right away.
        for (int r = 0; r < R; r++) apply(mk(1'b0, 1'b1, 1'b0, 2, r, 8'(8'h20 + r), r, 0));
        apply(mk(1'b0, 1'b0, 1'b1, 2, 0, 8'h00, 0, 0));
        idle(3, 2);
        apply(mk(1'b1, 1'b0, 1'b0, 2, 0, 8'h00, 6, 7));
        for (int b = 0; b < NB; b++) read_bank(b);
        apply(mk(1'b0, 1'b1, 1'b0, 2, 4, 8'h44, 4, 0));
        apply(mk(1'b0, 1'b0, 1'b1, 2, 0, 8'h00, 4, 0));
        idle(R + 2, 2);

        // Randomised traffic, including mid-clear bank changes and requests while busy.
        for (int i = 0; i < 1500; i++) begin
            apply(mk($urandom_range(0, 299) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 15) == 0,
                     int'($urandom_range(0, NB - 1)),
                     int'($urandom_range(0, R - 1)),
                     8'($urandom_range(0, 255)),
                     int'($urandom_range(0, R - 1)),
                     int'($urandom_range(0, R - 1))));
        end
        idle(R + 2, 0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
